// File: rtl/cla_bist_ctrl_if.sv
// Adder-side bus of the CLA self-test controller: operands out,
// sum and carry back. The controller is master, the adder is slave.
interface cla_bist_ctrl_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] dut_x;
    logic [WIDTH-1:0] dut_y;
    logic             dut_cin;
    logic [WIDTH-1:0] dut_r;
    logic             dut_cout;

    modport master (
        output dut_x, dut_y, dut_cin,
        input  dut_r, dut_cout
    );

    modport slave (
        input  dut_x, dut_y, dut_cin,
        output dut_r, dut_cout
    );
endinterface

// File: rtl/cla_bist_ctrl.sv
// On-board sweep generator and checker for a 4-bit carry-lookahead
// adder: 46 fixed vectors, error count, first failing index, verdict.
module cla_bist_ctrl #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    cla_bist_ctrl_if.master add_if,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [7:0]      err_count,
    output logic [5:0]      first_fail_idx,
    output logic            first_fail_vld,
    output logic [1:0]      phase
);
    localparam logic [5:0] LastIdx = 6'd45;
    localparam logic [3:0] SettleV = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    typedef struct packed {
        logic             cin;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
    } vec_t;

    state_e     state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic [3:0] wait_q, wait_d;
    vec_t       vec_q, vec_d;
    logic [7:0] err_q, err_d;
    logic [5:0] ffi_q, ffi_d;
    logic       ffv_q, ffv_d;
    logic [WIDTH:0] gold;
    logic       mism;

    // Phases 2 and 3 share one rule: x = y = idx - 30.
    function automatic vec_t vec_at(input logic [5:0] i);
        vec_t       v;
        logic [5:0] k;
        v = '0;
        k = '0;
        unique case (1'b1)
            (i < 6'd15): begin
                v.x = WIDTH'(i);
            end
            (i >= 6'd15 && i < 6'd30): begin
                k     = i - 6'd15;
                v.cin = 1'b1;
                v.x   = WIDTH'(k);
            end
            (i >= 6'd30): begin
                k     = i - 6'd30;
                v.cin = 1'b1;
                v.x   = WIDTH'(k);
                v.y   = WIDTH'(k);
            end
        endcase
        return v;
    endfunction

    function automatic logic [1:0] phase_of(input logic [5:0] i);
        logic [1:0] p;
        p = 2'd3;
        unique case (1'b1)
            (i < 6'd15):               p = 2'd0;
            (i >= 6'd15 && i < 6'd30): p = 2'd1;
            (i >= 6'd30 && i < 6'd38): p = 2'd2;
            (i >= 6'd38):              p = 2'd3;
        endcase
        return p;
    endfunction

    assign gold = {1'b0, vec_q.x}
                + {1'b0, vec_q.y}
                + {{WIDTH{1'b0}}, vec_q.cin};

    assign mism = (add_if.dut_r != gold[WIDTH-1:0])
               || (add_if.dut_cout != gold[WIDTH]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        vec_d   = vec_q;
        err_d   = err_q;
        ffi_d   = ffi_q;
        ffv_d   = ffv_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = WAIT;
                    idx_d   = '0;
                    vec_d   = vec_at(6'd0);
                    wait_d  = SettleV;
                    err_d   = '0;
                    ffi_d   = '0;
                    ffv_d   = 1'b0;
                end
            end
            WAIT: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    if (mism) begin
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                        if (!ffv_q) begin
                            ffi_d = idx_q;
                            ffv_d = 1'b1;
                        end
                    end
                    if (idx_q == LastIdx) begin
                        state_d = DONE;
                    end else begin
                        idx_d  = idx_q + 6'd1;
                        vec_d  = vec_at(idx_q + 6'd1);
                        wait_d = SettleV;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            ffi_q   <= '0;
            ffv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ffi_q   <= ffi_d;
            ffv_q   <= ffv_d;
        end
    end

    assign add_if.dut_x   = vec_q.x;
    assign add_if.dut_y   = vec_q.y;
    assign add_if.dut_cin = vec_q.cin;

    assign busy           = (state_q == WAIT);
    assign done           = (state_q == DONE);
    assign pass           = done && (err_q == 8'd0);
    assign err_count      = err_q;
    assign first_fail_idx = ffi_q;
    assign first_fail_vld = ffv_q;
    assign phase = (state_q == IDLE) ? 2'd0 : phase_of(idx_q);
endmodule
